// File: rtl/sprite_fetch.sv
// Sprite fetch: raster-scans one frame, reads the logo/cube ROMs for pixels under
// each sprite and streams decoder-ready pixel codes over a valid/ready handshake.
module sprite_fetch #(
    parameter int H_ACT  = 640,
    parameter int V_ACT  = 480,
    parameter int LOGO_W = 64,
    parameter int LOGO_H = 32,
    parameter int CUBE_W = 32,
    parameter int CUBE_H = 32,
    localparam int LOGO_AW = $clog2(LOGO_W * LOGO_H),
    localparam int CUBE_AW = $clog2(CUBE_W * CUBE_H)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [9:0]         logo_x_i,
    input  logic [9:0]         logo_y_i,
    input  logic [9:0]         cube_x_i,
    input  logic [9:0]         cube_y_i,
    output logic [LOGO_AW-1:0] logo_addr_o,
    output logic [CUBE_AW-1:0] cube_addr_o,
    output logic               rom_en_o,
    input  logic [1:0]         logo_rom_data_i,
    input  logic [1:0]         cube_rom_data_i,
    output logic [1:0]         pix_data_o,
    output logic [2:0]         sel_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               busy_o,
    output logic               frame_done_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e state_q;

    // Stage A: pixel currently presented to the ROMs.
    logic [10:0]        x_q, y_q, x_d, y_d;
    logic               logo_hit_q, cube_hit_q, logo_hit_d, cube_hit_d;
    logic [LOGO_AW-1:0] logo_addr_q, logo_addr_d;
    logic [CUBE_AW-1:0] cube_addr_q, cube_addr_d;

    // Stage B: hit flags paired with the ROM data that comes back a cycle later.
    logic b_valid_q, b_logo_hit_q, b_cube_hit_q;

    logic [9:0]  logo_x_q, logo_y_q, cube_x_q, cube_y_q;
    logic [10:0] logo_px, logo_py, cube_px, cube_py;
    logic        frame_done_q;
    logic        accept, advance, last_pix;

    assign accept   = (state_q == IDLE) && start_i;
    assign advance  = !b_valid_q || out_ready_i;
    assign last_pix = (x_q == 11'(H_ACT - 1)) && (y_q == 11'(V_ACT - 1));

    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
        logo_px = {1'b0, logo_x_q};
        logo_py = {1'b0, logo_y_q};
        cube_px = {1'b0, cube_x_q};
        cube_py = {1'b0, cube_y_q};
        x_d     = 11'd0;
        y_d     = 11'd0;
        if (accept) begin
            logo_px = {1'b0, logo_x_i};
            logo_py = {1'b0, logo_y_i};
            cube_px = {1'b0, cube_x_i};
            cube_py = {1'b0, cube_y_i};
        end else if (x_q == 11'(H_ACT - 1)) begin
            y_d = y_q + 11'd1;
        end else begin
            x_d = x_q + 11'd1;
            y_d = y_q;
        end

        // 11-bit bounds so a sprite placed near 1023 cannot wrap back into the frame.
        logo_hit_d = (x_d >= logo_px) && (x_d < logo_px + 11'(LOGO_W)) &&
                     (y_d >= logo_py) && (y_d < logo_py + 11'(LOGO_H));
        cube_hit_d = (x_d >= cube_px) && (x_d < cube_px + 11'(CUBE_W)) &&
                     (y_d >= cube_py) && (y_d < cube_py + 11'(CUBE_H));
        logo_addr_d = logo_hit_d ?
            LOGO_AW'((y_d - logo_py) * 11'(LOGO_W) + (x_d - logo_px)) : '0;
        cube_addr_d = cube_hit_d ?
            CUBE_AW'((y_d - cube_py) * 11'(CUBE_W) + (x_d - cube_px)) : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            logo_x_q     <= '0;
            logo_y_q     <= '0;
            cube_x_q     <= '0;
            cube_y_q     <= '0;
            logo_hit_q   <= 1'b0;
            cube_hit_q   <= 1'b0;
            logo_addr_q  <= '0;
            cube_addr_q  <= '0;
            b_valid_q    <= 1'b0;
            b_logo_hit_q <= 1'b0;
            b_cube_hit_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q     <= RUN;
                        logo_x_q    <= logo_x_i;
                        logo_y_q    <= logo_y_i;
                        cube_x_q    <= cube_x_i;
                        cube_y_q    <= cube_y_i;
                        x_q         <= x_d;
                        y_q         <= y_d;
                        logo_hit_q  <= logo_hit_d;
                        cube_hit_q  <= cube_hit_d;
                        logo_addr_q <= logo_addr_d;
                        cube_addr_q <= cube_addr_d;
                    end
                end
                RUN: begin
                    if (advance) begin
                        b_valid_q    <= 1'b1;
                        b_logo_hit_q <= logo_hit_q;
                        b_cube_hit_q <= cube_hit_q;
                        if (last_pix) begin
                            state_q <= DRAIN;
                        end else begin
                            x_q         <= x_d;
                            y_q         <= y_d;
                            logo_hit_q  <= logo_hit_d;
                            cube_hit_q  <= cube_hit_d;
                            logo_addr_q <= logo_addr_d;
                            cube_addr_q <= cube_addr_d;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready_i) begin
                        state_q      <= IDLE;
                        b_valid_q    <= 1'b0;
                        b_logo_hit_q <= 1'b0;
                        b_cube_hit_q <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign logo_addr_o  = logo_addr_q;
    assign cube_addr_o  = cube_addr_q;
    assign rom_en_o     = (state_q == RUN) && advance;
    assign out_valid_o  = b_valid_q;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = frame_done_q;
    assign sel_o        = b_logo_hit_q ? 3'b111 : (b_cube_hit_q ? 3'b110 : 3'b000);
    assign pix_data_o   = b_logo_hit_q ? logo_rom_data_i :
                          (b_cube_hit_q ? cube_rom_data_i : 2'b00);

endmodule

// File: tb/tb_sprite_fetch.sv
// Self-checking bench for sprite_fetch on a reduced frame: a ROM model plus a
// pixel-by-pixel reference derived from the sprite placement rules.
module tb_sprite_fetch;

    localparam int H   = 96;
    localparam int V   = 48;
    localparam int LW  = 64;
    localparam int LH  = 32;
    localparam int CW  = 32;
    localparam int CH  = 32;
    localparam int P   = H * V;
    localparam int LAW = $clog2(LW * LH);
    localparam int CAW = $clog2(CW * CH);

    logic           clk = 1'b0;
    logic           rst_i, start_i, out_ready_i;
    logic [9:0]     logo_x_i, logo_y_i, cube_x_i, cube_y_i;
    logic [LAW-1:0] logo_addr_o;
    logic [CAW-1:0] cube_addr_o;
    logic           rom_en_o, out_valid_o, busy_o, frame_done_o;
    logic [1:0]     logo_rom_data_i, cube_rom_data_i, pix_data_o;
    logic [2:0]     sel_o;

    always #5 clk = ~clk;

    sprite_fetch #(
        .H_ACT(H), .V_ACT(V), .LOGO_W(LW), .LOGO_H(LH), .CUBE_W(CW), .CUBE_H(CH)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .logo_x_i(logo_x_i), .logo_y_i(logo_y_i), .cube_x_i(cube_x_i), .cube_y_i(cube_y_i),
        .logo_addr_o(logo_addr_o), .cube_addr_o(cube_addr_o), .rom_en_o(rom_en_o),
        .logo_rom_data_i(logo_rom_data_i), .cube_rom_data_i(cube_rom_data_i),
        .pix_data_o(pix_data_o), .sel_o(sel_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .busy_o(busy_o), .frame_done_o(frame_done_o)
    );

    // Synchronous ROMs: data follows an enabled read by one cycle and holds otherwise.
    logic [1:0] logo_rom [LW*LH];
    logic [1:0] cube_rom [CW*CH];
    always @(posedge clk) begin
        if (rom_en_o) begin
            logo_rom_data_i <= logo_rom[logo_addr_o];
            cube_rom_data_i <= cube_rom[cube_addr_o];
        end
    end

    int n_checks = 0;
    int n_fails  = 0;
    logic [LAW-1:0] la_q[$];
    logic [CAW-1:0] ca_q[$];
    int obs_sel [P];
    int obs_la  [P];
    int obs_ca  [P];

    function automatic void model_pixel(input int x, input int y, input int lx, input int ly,
                                        input int cx, input int cy,
                                        output logic [2:0] sel, output logic [1:0] pix,
                                        output int la, output int ca);
        bit lh, ch;
        lh = (x >= lx) && (x < lx + LW) && (y >= ly) && (y < ly + LH);
        ch = (x >= cx) && (x < cx + CW) && (y >= cy) && (y < cy + CH);
        la = lh ? (y - ly) * LW + (x - lx) : 0;
        ca = ch ? (y - cy) * CW + (x - cx) : 0;
        if (lh) begin
            sel = 3'b111; pix = logo_rom[la];
        end else if (ch) begin
            sel = 3'b110; pix = cube_rom[ca];
        end else begin
            sel = 3'b000; pix = 2'b00;
        end
    endfunction

    function automatic int px(input int x, input int y);
        return y * H + x;
    endfunction

    // Runs one frame and checks every transfer against the model; optionally issues
    // a stray start mid-frame, or the next start in the frame_done cycle.
    task automatic run_frame(input string name, input int lx, input int ly, input int cx,
                             input int cy, input int ready_pct, input bit skip_start,
                             input bit mid_start, input bit chain, input int nlx,
                             input int nly, input int ncx, input int ncy);
        int c, n, errs, flow_errs, first_valid, done_c, last_x, budget, bad_n, la, ca;
        logic [2:0] e_sel, h_sel, bad_sel, bad_esel;
        logic [1:0] e_pix, h_pix;
        logic [LAW-1:0] a_la;
        logic [CAW-1:0] a_ca;
        bit hold, prev_x, done_busy;
        c = 0; n = 0; errs = 0; flow_errs = 0; first_valid = -1; done_c = -1; last_x = -1;
        bad_n = -1; bad_sel = '0; bad_esel = '0; hold = 0; prev_x = 0; done_busy = 1;
        h_sel = '0; h_pix = '0; budget = 4 * P + 100;
        la_q.delete();
        ca_q.delete();
        for (int i = 0; i < P; i++) begin
            obs_sel[i] = -1; obs_la[i] = -1; obs_ca[i] = -1;
        end
        if (!skip_start) begin
            @(negedge clk);
            start_i  = 1'b1;
            logo_x_i = 10'(lx); logo_y_i = 10'(ly);
            cube_x_i = 10'(cx); cube_y_i = 10'(cy);
        end
        while (done_c < 0 && c < budget) begin
            @(negedge clk);
            c++;
            start_i     = mid_start && (c == 100);
            logo_x_i    = 10'($urandom); logo_y_i = 10'($urandom);
            cube_x_i    = 10'($urandom); cube_y_i = 10'($urandom);
            out_ready_i = ($urandom_range(0, 99) < ready_pct);
            #1;
            if (c == 1) begin
                n_checks++;
                if ({busy_o, out_valid_o, frame_done_o} !== 3'b100) begin
                    n_fails++;
                    $display("FAIL %s_first_cycle: busy/valid/done=%b required 100", name,
                             {busy_o, out_valid_o, frame_done_o});
                end
            end
            if (rom_en_o === 1'b1) begin
                la_q.push_back(logo_addr_o);
                ca_q.push_back(cube_addr_o);
            end
            if (out_valid_o === 1'b1 && first_valid < 0) first_valid = c;
            if (hold && (out_valid_o !== 1'b1 || sel_o !== h_sel || pix_data_o !== h_pix))
                flow_errs++;
            if (prev_x && n < P && out_valid_o !== 1'b1) flow_errs++;
            if (frame_done_o === 1'b1) begin
                done_c = c;
                done_busy = busy_o;
            end else if (out_valid_o === 1'b1 && out_ready_i) begin
                model_pixel(n % H, n / H, lx, ly, cx, cy, e_sel, e_pix, la, ca);
                if (la_q.size() == 0) begin
                    errs++;
                end else begin
                    a_la = la_q.pop_front();
                    a_ca = ca_q.pop_front();
                    if (n < P) begin
                        obs_sel[n] = int'(sel_o); obs_la[n] = int'(a_la); obs_ca[n] = int'(a_ca);
                    end
                    if (sel_o !== e_sel || pix_data_o !== e_pix ||
                        a_la !== LAW'(la) || a_ca !== CAW'(ca)) begin
                        if (bad_n < 0) begin
                            bad_n = n; bad_sel = sel_o; bad_esel = e_sel;
                        end
                        errs++;
                    end
                end
                n++;
                last_x = c;
            end
            hold   = (out_valid_o === 1'b1) && !out_ready_i;
            h_sel  = sel_o;
            h_pix  = pix_data_o;
            prev_x = (out_valid_o === 1'b1) && out_ready_i;
        end

        n_checks++;
        if (done_c < 0) begin
            n_fails++;
            $display("FAIL %s_timeout: no frame_done after %0d cycles, %0d transfers", name, c, n);
            rst_i = 1'b1;
            @(negedge clk);
            rst_i = 1'b0;
        end
        n_checks++;
        if (first_valid != 2) begin
            n_fails++;
            $display("FAIL %s_latency: first out_valid at cycle %0d required 2", name, first_valid);
        end
        n_checks++;
        if (n != P) begin
            n_fails++;
            $display("FAIL %s_count: %0d transfers required %0d", name, n, P);
        end
        n_checks++;
        if (errs != 0) begin
            n_fails++;
            $display("FAIL %s_stream: %0d wrong pixels, first #%0d (%0d,%0d) sel=%b required %b",
                     name, errs, bad_n, bad_n % H, bad_n / H, bad_sel, bad_esel);
        end
        n_checks++;
        if (flow_errs != 0) begin
            n_fails++;
            $display("FAIL %s_flow: %0d hold/gap violations required 0", name, flow_errs);
        end
        n_checks++;
        if (done_c != last_x + 1 || done_busy !== 1'b0) begin
            n_fails++;
            $display("FAIL %s_done: frame_done at %0d busy=%b, required %0d busy=0", name,
                     done_c, done_busy, last_x + 1);
        end
        if (ready_pct == 100) begin
            n_checks++;
            if (done_c != P + 2) begin
                n_fails++;
                $display("FAIL %s_throughput: frame_done at cycle %0d required %0d", name,
                         done_c, P + 2);
            end
        end
        if (chain && done_c >= 0) begin
            start_i  = 1'b1;
            logo_x_i = 10'(nlx); logo_y_i = 10'(nly);
            cube_x_i = 10'(ncx); cube_y_i = 10'(ncy);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b1; out_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({out_valid_o, busy_o, frame_done_o, rom_en_o} !== 4'b0000) begin
            n_fails++;
            $display("FAIL reset_ctrl: valid/busy/done/rom_en=%b required 0000",
                     {out_valid_o, busy_o, frame_done_o, rom_en_o});
        end
        n_checks++;
        if ({sel_o, pix_data_o} !== 5'b0) begin
            n_fails++;
            $display("FAIL reset_data: sel=%b pix=%b required 000/00", sel_o, pix_data_o);
        end
        n_checks++;
        if (logo_addr_o !== '0 || cube_addr_o !== '0) begin
            n_fails++;
            $display("FAIL reset_addr: logo=%0d cube=%0d required 0/0", logo_addr_o, cube_addr_o);
        end
        @(negedge clk);
        rst_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || rom_en_o !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_start_ignored: busy=%b rom_en=%b required 0/0", busy_o, rom_en_o);
        end
    endtask

    task automatic test_basic();
        run_frame("basic", 0, 0, 64, 16, 100, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs_sel[0] != 7 || obs_la[0] != 0) begin
            n_fails++;
            $display("FAIL basic_first_pixel: sel=%0d logo_addr=%0d required 7/0", obs_sel[0], obs_la[0]);
        end
        n_checks++;
        if (obs_sel[px(64, 16)] != 6 || obs_ca[px(64, 16)] != 0) begin
            n_fails++;
            $display("FAIL basic_cube_corner: sel=%0d cube_addr=%0d required 6/0",
                     obs_sel[px(64, 16)], obs_ca[px(64, 16)]);
        end
    endtask

    task automatic test_overlap();
        run_frame("overlap", 10, 5, 60, 15, 100, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs_sel[px(35, 20)] != 7) begin
            n_fails++;
            $display("FAIL overlap_logo: sel=%0d required 7", obs_sel[px(35, 20)]);
        end
        n_checks++;
        if (obs_sel[px(80, 20)] != 6 || obs_ca[px(80, 20)] != 180) begin
            n_fails++;
            $display("FAIL overlap_cube: sel=%0d cube_addr=%0d required 6/180",
                     obs_sel[px(80, 20)], obs_ca[px(80, 20)]);
        end
        n_checks++;
        if (obs_sel[px(65, 20)] != 7 || obs_la[px(65, 20)] != 1015) begin
            n_fails++;
            $display("FAIL overlap_priority: sel=%0d logo_addr=%0d required 7/1015",
                     obs_sel[px(65, 20)], obs_la[px(65, 20)]);
        end
    endtask

    task automatic test_clip();
        int n_cube, n_logo;
        n_cube = 0; n_logo = 0;
        run_frame("clip", 1000, 0, 86, 38, 100, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < P; i++) begin
            if (obs_sel[i] == 6) n_cube++;
            if (obs_sel[i] == 7) n_logo++;
        end
        n_checks++;
        if (n_cube != 100 || n_logo != 0) begin
            n_fails++;
            $display("FAIL clip_counts: cube=%0d logo=%0d required 100/0", n_cube, n_logo);
        end
        n_checks++;
        if (obs_sel[px(95, 47)] != 6 || obs_ca[px(95, 47)] != 297) begin
            n_fails++;
            $display("FAIL clip_corner: sel=%0d cube_addr=%0d required 6/297",
                     obs_sel[px(95, 47)], obs_ca[px(95, 47)]);
        end
    endtask

    task automatic test_random_stall();
        run_frame("stall", int'($urandom_range(0, H)), int'($urandom_range(0, V)),
                  int'($urandom_range(0, H)), int'($urandom_range(0, V)), 50, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        start_i = 1'b1; out_ready_i = 1'b1;
        logo_x_i = 10'd30; logo_y_i = 10'd4; cube_x_i = 10'd40; cube_y_i = 10'd8;
        @(negedge clk);
        start_i = 1'b0;
        repeat (px(40, 10) + 1) @(negedge clk);
        #1;
        n_checks++;
        if (out_valid_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fails++;
            $display("FAIL midreset_active: valid=%b busy=%b required 1/1", out_valid_o, busy_o);
        end
        rst_i = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || rom_en_o !== 1'b0) begin
            n_fails++;
            $display("FAIL midreset_abandon: valid=%b busy=%b rom_en=%b required 0/0/0",
                     out_valid_o, busy_o, rom_en_o);
        end
        rst_i = 1'b0;
        run_frame("restart", 30, 4, 40, 8, 100, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_start_ignored();
        run_frame("midstart", 20, 8, 50, 20, 70, 0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_frame("chain_a", 5, 3, 70, 30, 100, 0, 0, 1, 40, 20, 2, 2);
        run_frame("chain_b", 40, 20, 2, 2, 100, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; out_ready_i = 1'b0;
        logo_x_i = '0; logo_y_i = '0; cube_x_i = '0; cube_y_i = '0;
        for (int i = 0; i < LW * LH; i++) logo_rom[i] = 2'($urandom);
        for (int i = 0; i < CW * CH; i++) cube_rom[i] = 2'($urandom);
        test_reset();
        test_basic();
        test_overlap();
        test_clip();
        test_random_stall();
        test_mid_reset();
        test_start_ignored();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
